// File: rtl/dmem_if.sv
// Core-to-data-memory request/response bundle: a valid/ready request channel and
// a one-cycle response strobe that cannot be backpressured.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, programmable wait states, RISC-V widths.
// Build option DMEM_FAST_STORE_EN: stores skip the wait phase (fixed 2-cycle latency).
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | ready for a request; latches it on valid
// S_WAIT   | burning wait states, counter counts down to 1
// S_ACCESS | error check, memory write or read + extension
// S_RESP   | resp_valid high for this single cycle
module dmem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus,
    output logic  busy
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** IDX_W;
`ifdef DMEM_FAST_STORE_EN
    localparam bit FAST_STORE = 1'b1;
`else
    localparam bit FAST_STORE = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0] mem [DEPTH];

    logic [IDX_W-1:0] idx;
    logic [31:0]      word;
    logic [31:0]      shifted;
    logic [15:0]      half;
    logic [31:0]      load_data;
    logic             legal_f3;
    logic             misalign;
    logic             out_of_range;
    logic             acc_err;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic             mem_we;

    assign idx     = addr_q[ADDR_WIDTH-1:2];
    assign word    = mem[idx];
    assign shifted = word >> {addr_q[1:0], 3'b000};
    assign half    = addr_q[1] ? word[31:16] : word[15:0];

    always_comb begin
        legal_f3     = 1'b0;
        misalign     = 1'b0;
        out_of_range = |(addr_q >> ADDR_WIDTH);
        load_data    = 32'h0;
        wr_be        = 4'b0000;
        wr_data      = wdata_q;
        case (funct3_q)
            3'b000: begin
                legal_f3  = 1'b1;
                load_data = {{24{shifted[7]}}, shifted[7:0]};
                wr_be     = 4'b0001 << addr_q[1:0];
                wr_data   = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                legal_f3  = 1'b1;
                misalign  = addr_q[0];
                load_data = {{16{half[15]}}, half};
                wr_be     = addr_q[1] ? 4'b1100 : 4'b0011;
                wr_data   = {2{wdata_q[15:0]}};
            end
            3'b010: begin
                legal_f3  = 1'b1;
                misalign  = |addr_q[1:0];
                load_data = word;
                wr_be     = 4'b1111;
            end
            3'b100: begin
                legal_f3  = !we_q;
                load_data = {24'h0, shifted[7:0]};
            end
            3'b101: begin
                legal_f3  = !we_q;
                misalign  = addr_q[0];
                load_data = {16'h0, half};
            end
            default: legal_f3 = 1'b0;
        endcase
        acc_err = !legal_f3 || misalign || out_of_range;
    end

    // Gated by rst so a store whose access edge coincides with reset is dropped.
    assign mem_we = (state_q == S_ACCESS) && we_q && !acc_err && rst;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_we && wr_be[b]) begin
                mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    addr_d   = bus.req_addr;
                    funct3_d = bus.req_funct3;
                    wdata_d  = bus.req_wdata;
                    cnt_d    = 4'(WAIT_STATES);
                    if ((FAST_STORE && bus.req_we) || WAIT_STATES == 0) begin
                        state_d = S_ACCESS;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                resp_valid_d = 1'b1;
                resp_err_d   = acc_err;
                resp_rdata_d = (we_q || acc_err) ? 32'h0 : load_data;
                state_d      = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            we_q         <= 1'b0;
            addr_q       <= 32'h0;
            funct3_q     <= 3'b000;
            wdata_q      <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign busy           = (state_q != S_IDLE);

endmodule
